oc8051_ecall_ctrl: RTL and testbench

OC8051_ECALL_CTRL -- requirements
Module: oc8051_ecall_ctrl

---
 rtl/oc8051_ecall_ctrl.sv | 150 +++++++++++++++
 tb/tb_oc8051_ecall_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc8051_ecall_ctrl.sv
// ECALL/ERET privilege controller for the oc8051 core.
// Saves the return PC on ECALL, redirects fetch to the ETR target, and
// returns to the saved PC on ERET. An illegal ecall or eret sets a sticky fault.
//
// Redirect handshake: redir_valid is high for as long as the FSM is in S_ENTER
// or S_EXIT. redir_pc is held constant while redir_valid=1. A transfer happens
// on a posedge where redir_valid and redir_ready are both 1. redir_ready has
// no effect while redir_valid=0.

`ifndef OC8051_SFR_EPC_LO
`define OC8051_SFR_EPC_LO 8'hE6
`endif
`ifndef OC8051_SFR_EPC_HI
`define OC8051_SFR_EPC_HI 8'hE7
`endif

module oc8051_ecall_ctrl #(
    parameter logic RESET_PRIV = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall,
    input  logic        eret,
    input  logic [15:0] ret_pc,
    input  logic [15:0] etr,
    input  logic        fault_clr,
    input  logic [7:0]  rd_addr,
    output logic [7:0]  sfr_data,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [15:0] redir_pc,
    output logic        priv_lvl,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_USER  = 2'd0,
        S_ENTER = 2'd1,
        S_PRIV  = 2'd2,
        S_EXIT  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_PRIV ? S_PRIV : S_USER;

    state_t      state, state_n;
    logic [15:0] epc, epc_n;
    logic [15:0] tgt, tgt_n;
    logic        priv_n;
    logic        fault_n;
    logic        fault_ev;
    logic        handshake;

    // State and data registers; reset abandons any pending redirect at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_STATE;
            epc      <= 16'h0000;
            tgt      <= 16'h0000;
            priv_lvl <= RESET_PRIV;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            epc      <= epc_n;
            tgt      <= tgt_n;
            priv_lvl <= priv_n;
            fault    <= fault_n;
        end
    end

    // Next-state logic, redirect outputs and fault detection.
    always_comb begin
        state_n     = state;
        epc_n       = epc;
        tgt_n       = tgt;
        priv_n      = priv_lvl;
        fault_ev    = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = tgt;
        busy        = 1'b0;
        handshake   = 1'b0;

        case (state)
            S_USER: begin
                if (eret) begin
                    // eret alone or together with ecall is illegal here
                    fault_ev = 1'b1;
                end else if (ecall) begin
                    epc_n   = ret_pc;
                    tgt_n   = etr;
                    state_n = S_ENTER;
                end
            end
            S_ENTER: begin
                redir_valid = 1'b1;
                redir_pc    = tgt;
                busy        = 1'b1;
                handshake   = redir_ready;
                if (handshake) begin
                    state_n = S_PRIV;
                    priv_n  = 1'b1;
                end
            end
            S_PRIV: begin
                if (ecall) begin
                    // ecall alone or together with eret is illegal here
                    fault_ev = 1'b1;
                end else if (eret) begin
                    state_n = S_EXIT;
                end
            end
            S_EXIT: begin
                redir_valid = 1'b1;
                redir_pc    = epc;
                busy        = 1'b1;
                handshake   = redir_ready;
                if (handshake) begin
                    state_n = S_USER;
                    priv_n  = 1'b0;
                end
            end
            default: state_n = RESET_STATE;
        endcase

        // A new fault event wins over a simultaneous clear.
        if (fault_ev) begin
            fault_n = 1'b1;
        end else if (fault_clr) begin
            fault_n = 1'b0;
        end else begin
            fault_n = fault;
        end
    end

    // EPC bytes are readable only from privileged mode.
    always_comb begin
        sfr_data = 8'h00;
        if (priv_lvl) begin
            if (rd_addr == `OC8051_SFR_EPC_LO) begin
                sfr_data = epc[7:0];
            end else if (rd_addr == `OC8051_SFR_EPC_HI) begin
                sfr_data = epc[15:8];
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_oc8051_ecall_ctrl.sv
// Directed testbench for oc8051_ecall_ctrl, instantiated with RESET_PRIV=0.
`ifndef OC8051_SFR_EPC_LO
`define OC8051_SFR_EPC_LO 8'hE6
`endif
`ifndef OC8051_SFR_EPC_HI
`define OC8051_SFR_EPC_HI 8'hE7
`endif

module tb_oc8051_ecall_ctrl;

    localparam logic [1:0] ST_USER  = 2'd0;
    localparam logic [1:0] ST_ENTER = 2'd1;
    localparam logic [1:0] ST_PRIV  = 2'd2;
    localparam logic [1:0] ST_EXIT  = 2'd3;

    logic        clk;
    logic        rst;
    logic        ecall;
    logic        eret;
    logic [15:0] ret_pc;
    logic [15:0] etr;
    logic        fault_clr;
    logic [7:0]  rd_addr;
    logic [7:0]  sfr_data;
    logic        redir_valid;
    logic        redir_ready;
    logic [15:0] redir_pc;
    logic        priv_lvl;
    logic        busy;
    logic        fault;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;

    oc8051_ecall_ctrl #(.RESET_PRIV(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .ecall       (ecall),
        .eret        (eret),
        .ret_pc      (ret_pc),
        .etr         (etr),
        .fault_clr   (fault_clr),
        .rd_addr     (rd_addr),
        .sfr_data    (sfr_data),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .priv_lvl    (priv_lvl),
        .busy        (busy),
        .fault       (fault),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ecall = 1'b0; eret = 1'b0; ret_pc = 16'h0000; etr = 16'h0000;
        fault_clr = 1'b0; rd_addr = 8'h00; redir_ready = 1'b0;
        #12;
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", redir_valid); end
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL reset_priv got=%b exp=0", priv_lvl); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fault); end
        n_checks++; if (dbg_state !== ST_USER) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_USER); end
        tick();
        rst = 1'b1;
        tick();
        // ready alone in S_USER must not start anything
        redir_ready = 1'b1;
        tick();
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_valid got=%b exp=0", redir_valid); end
        n_checks++; if (dbg_state !== ST_USER) begin n_fail++; $display("FAIL idle_ready_state got=%0d exp=%0d", dbg_state, ST_USER); end
    endtask

    task automatic test_basic_ecall();
        etr = 16'h1234; ret_pc = 16'h0456; redir_ready = 1'b1; ecall = 1'b1;
        tick();
        ecall = 1'b0; etr = 16'hAAAA; ret_pc = 16'h5555;
        n_checks++; if (redir_valid !== 1'b1) begin n_fail++; $display("FAIL ecall_valid got=%b exp=1", redir_valid); end
        n_checks++; if (redir_pc !== 16'h1234) begin n_fail++; $display("FAIL ecall_pc got=%h exp=1234", redir_pc); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ecall_busy got=%b exp=1", busy); end
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL ecall_priv_early got=%b exp=0", priv_lvl); end
        tick();
        n_checks++; if (priv_lvl !== 1'b1) begin n_fail++; $display("FAIL ecall_priv got=%b exp=1", priv_lvl); end
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL ecall_valid_drop got=%b exp=0", redir_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ecall_busy_drop got=%b exp=0", busy); end
        rd_addr = `OC8051_SFR_EPC_LO; #1;
        n_checks++; if (sfr_data !== 8'h56) begin n_fail++; $display("FAIL epc_lo got=%h exp=56", sfr_data); end
        rd_addr = `OC8051_SFR_EPC_HI; #1;
        n_checks++; if (sfr_data !== 8'h04) begin n_fail++; $display("FAIL epc_hi got=%h exp=04", sfr_data); end
        rd_addr = 8'h81; #1;
        n_checks++; if (sfr_data !== 8'h00) begin n_fail++; $display("FAIL epc_other got=%h exp=00", sfr_data); end
    endtask

    task automatic test_return();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (redir_valid !== 1'b1) begin n_fail++; $display("FAIL eret_valid got=%b exp=1", redir_valid); end
        n_checks++; if (redir_pc !== 16'h0456) begin n_fail++; $display("FAIL eret_pc got=%h exp=0456", redir_pc); end
        n_checks++; if (priv_lvl !== 1'b1) begin n_fail++; $display("FAIL eret_priv_early got=%b exp=1", priv_lvl); end
        tick();
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL eret_priv got=%b exp=0", priv_lvl); end
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL eret_valid_drop got=%b exp=0", redir_valid); end
        rd_addr = `OC8051_SFR_EPC_LO; #1;
        n_checks++; if (sfr_data !== 8'h00) begin n_fail++; $display("FAIL user_epc_lo got=%h exp=00", sfr_data); end
        rd_addr = `OC8051_SFR_EPC_HI; #1;
        n_checks++; if (sfr_data !== 8'h00) begin n_fail++; $display("FAIL user_epc_hi got=%h exp=00", sfr_data); end
    endtask

    task automatic test_backpressure();
        etr = 16'h1234; ret_pc = 16'h0456; redir_ready = 1'b0; ecall = 1'b1;
        tick();
        ecall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (redir_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, redir_valid); end
            n_checks++; if (redir_pc !== 16'h1234) begin n_fail++; $display("FAIL bp_pc[%0d] got=%h exp=1234", i, redir_pc); end
            n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL bp_priv[%0d] got=%b exp=0", i, priv_lvl); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d] got=%b exp=1", i, busy); end
            // pulses while busy are ignored and raise no fault
            eret  = (i == 1);
            ecall = (i == 3);
            tick();
            eret = 1'b0; ecall = 1'b0;
        end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL bp_busy_pulse_fault got=%b exp=0", fault); end
        n_checks++; if (redir_pc !== 16'h1234) begin n_fail++; $display("FAIL bp_pc_hold got=%h exp=1234", redir_pc); end
        redir_ready = 1'b1;
        tick();
        n_checks++; if (priv_lvl !== 1'b1) begin n_fail++; $display("FAIL bp_priv_after got=%b exp=1", priv_lvl); end
        n_checks++; if (dbg_state !== ST_PRIV) begin n_fail++; $display("FAIL bp_state got=%0d exp=%0d", dbg_state, ST_PRIV); end
        // exit with backpressure for 2 cycles
        redir_ready = 1'b0; eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        n_checks++; if (dbg_state !== ST_EXIT) begin n_fail++; $display("FAIL bp_exit_hold got=%0d exp=%0d", dbg_state, ST_EXIT); end
        n_checks++; if (redir_pc !== 16'h0456) begin n_fail++; $display("FAIL bp_exit_pc got=%h exp=0456", redir_pc); end
        redir_ready = 1'b1;
        tick();
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL bp_exit_priv got=%b exp=0", priv_lvl); end
    endtask

    task automatic test_faults();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL user_eret_fault got=%b exp=1", fault); end
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL user_eret_valid got=%b exp=0", redir_valid); end
        n_checks++; if (dbg_state !== ST_USER) begin n_fail++; $display("FAIL user_eret_state got=%0d exp=%0d", dbg_state, ST_USER); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL clr1 got=%b exp=0", fault); end
        // both pulses in S_USER
        ecall = 1'b1; eret = 1'b1;
        tick();
        ecall = 1'b0; eret = 1'b0;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL user_both_fault got=%b exp=1", fault); end
        n_checks++; if (dbg_state !== ST_USER) begin n_fail++; $display("FAIL user_both_state got=%0d exp=%0d", dbg_state, ST_USER); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        // enter S_PRIV
        etr = 16'h2000; ret_pc = 16'h0100; redir_ready = 1'b1; ecall = 1'b1;
        tick();
        ecall = 1'b0;
        tick();
        n_checks++; if (priv_lvl !== 1'b1) begin n_fail++; $display("FAIL fault_enter_priv got=%b exp=1", priv_lvl); end
        // ecall in S_PRIV together with fault_clr: fault wins
        ecall = 1'b1; fault_clr = 1'b1;
        tick();
        ecall = 1'b0; fault_clr = 1'b0;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL priv_ecall_clr_fault got=%b exp=1", fault); end
        n_checks++; if (dbg_state !== ST_PRIV) begin n_fail++; $display("FAIL priv_ecall_state got=%0d exp=%0d", dbg_state, ST_PRIV); end
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL priv_ecall_valid got=%b exp=0", redir_valid); end
        tick();
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky got=%b exp=1", fault); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL clr2 got=%b exp=0", fault); end
        // both pulses in S_PRIV
        ecall = 1'b1; eret = 1'b1;
        tick();
        ecall = 1'b0; eret = 1'b0;
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL priv_both_fault got=%b exp=1", fault); end
        n_checks++; if (dbg_state !== ST_PRIV) begin n_fail++; $display("FAIL priv_both_state got=%0d exp=%0d", dbg_state, ST_PRIV); end
        fault_clr = 1'b1;
        // return to user
        eret = 1'b1;
        tick();
        eret = 1'b0; fault_clr = 1'b0;
        n_checks++; if (redir_pc !== 16'h0100) begin n_fail++; $display("FAIL fault_exit_pc got=%h exp=0100", redir_pc); end
        tick();
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL fault_exit_priv got=%b exp=0", priv_lvl); end
    endtask

    task automatic test_reset_mid_enter();
        etr = 16'h3333; ret_pc = 16'h4444; redir_ready = 1'b0; ecall = 1'b1;
        tick();
        ecall = 1'b0;
        n_checks++; if (redir_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", redir_valid); end
        rst = 1'b0; #1;
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", redir_valid); end
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL mid_rst_priv got=%b exp=0", priv_lvl); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        tick();
        rst = 1'b1; redir_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (redir_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_valid got=%b exp=0", redir_valid); end
        n_checks++; if (dbg_state !== ST_USER) begin n_fail++; $display("FAIL mid_release_state got=%0d exp=%0d", dbg_state, ST_USER); end
    endtask

    task automatic test_boundary();
        etr = 16'hFFFF; ret_pc = 16'h0000; redir_ready = 1'b1; ecall = 1'b1;
        tick();
        ecall = 1'b0;
        n_checks++; if (redir_pc !== 16'hFFFF) begin n_fail++; $display("FAIL bnd_enter_pc got=%h exp=ffff", redir_pc); end
        tick();
        rd_addr = `OC8051_SFR_EPC_HI; #1;
        n_checks++; if (sfr_data !== 8'h00) begin n_fail++; $display("FAIL bnd_epc_hi got=%h exp=00", sfr_data); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (redir_pc !== 16'h0000) begin n_fail++; $display("FAIL bnd_exit_pc got=%h exp=0000", redir_pc); end
        tick();
        n_checks++; if (priv_lvl !== 1'b0) begin n_fail++; $display("FAIL bnd_exit_priv got=%b exp=0", priv_lvl); end
        // reverse boundary: epc=FFFF read back byte-wise
        etr = 16'h0000; ret_pc = 16'hFFFF; ecall = 1'b1;
        tick();
        ecall = 1'b0;
        n_checks++; if (redir_pc !== 16'h0000) begin n_fail++; $display("FAIL bnd2_enter_pc got=%h exp=0000", redir_pc); end
        tick();
        rd_addr = `OC8051_SFR_EPC_LO; #1;
        n_checks++; if (sfr_data !== 8'hFF) begin n_fail++; $display("FAIL bnd2_epc_lo got=%h exp=ff", sfr_data); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (redir_pc !== 16'hFFFF) begin n_fail++; $display("FAIL bnd2_exit_pc got=%h exp=ffff", redir_pc); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_ecall();
        test_return();
        test_backpressure();
        test_faults();
        test_reset_mid_enter();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
